// File: rtl/mem_region_perf_monitor.sv
`default_nettype none
// =============================================================================
// mem_region_perf_monitor : loop/total cycle timer with per-region store counters.
// Optional feature macro: PERF_MON_SAT_EN (saturating counters instead of wrapping).
// Revision: 1.0
// =============================================================================
module mem_region_perf_monitor #(
  parameter int NUM_REGIONS  = 2,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             cfg_start_pc,
  input  logic [ADDR_W-1:0]             cfg_end_addr,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_region_lo,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_region_hi,
  input  logic [ADDR_W-1:0]             pc,
  input  logic                          store_valid,
  input  logic [ADDR_W-1:0]             store_addr,
  input  logic                          ext_done,
  output logic [1:0]                    state_o,
  output logic [CNT_W-1:0]              total_cycles,
  output logic [CNT_W-1:0]              loop_cycles,
  output logic [CNT_W-1:0]              store_events,
  output logic [NUM_REGIONS*CNT_W-1:0]  region_count,
  output logic [NUM_REGIONS*ADDR_W-1:0] region_last,
  output logic                          end_seen,
  output logic                          done
);

  localparam int c_DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES - 1);
`ifdef PERF_MON_SAT_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [c_DRAIN_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]       total_q, total_d;
  logic [CNT_W-1:0]       start_q, start_d;
  logic [CNT_W-1:0]       loop_q, loop_d;
  logic [CNT_W-1:0]       events_q, events_d;
  logic                   end_seen_q, end_seen_d;
  logic                   prev_store_q, prev_store_d;

  logic                   w_count_en;
  logic                   w_end_hit;
  logic [CNT_W-1:0]       w_loop;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef PERF_MON_SAT_EN
    cnt_inc = (v == c_CNT_MAX) ? v : v + CNT_W'(1);
`else
    cnt_inc = v + CNT_W'(1);
`endif
  endfunction

  assign w_count_en = (state_q != S_DONE);
  assign w_end_hit  = store_valid && (store_addr == cfg_end_addr);

  // Modular subtraction keeps the result correct across one wrap of total_q.
  always_comb begin
    w_loop = total_q - start_q + CNT_W'(1);
`ifdef PERF_MON_SAT_EN
    if (total_q == c_CNT_MAX) begin
      w_loop = c_CNT_MAX;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    start_d      = start_q;
    loop_d       = loop_q;
    end_seen_d   = end_seen_q;
    total_d      = cnt_inc(total_q);
    events_d     = events_q;
    prev_store_d = store_valid;

    if (w_count_en && store_valid && !prev_store_q) begin
      events_d = cnt_inc(events_q);
    end

    case (state_q)
      S_IDLE: begin
        // A start hit takes priority; an end store in the same cycle is ignored.
        if (pc == cfg_start_pc) begin
          state_d = S_RUN;
          start_d = total_q;
        end else if (ext_done) begin
          state_d = S_DRAIN;
          drain_d = c_DRAIN_LOAD;
        end
      end
      S_RUN: begin
        if (w_end_hit || ext_done) begin
          state_d = S_DRAIN;
          drain_d = c_DRAIN_LOAD;
        end
        if (w_end_hit) begin
          end_seen_d = 1'b1;
          loop_d     = w_loop;
        end
      end
      S_DRAIN: begin
        if (w_end_hit && !end_seen_q) begin
          end_seen_d = 1'b1;
          loop_d     = w_loop;
        end
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - c_DRAIN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      drain_q      <= '0;
      total_q      <= '0;
      start_q      <= '0;
      loop_q       <= '0;
      events_q     <= '0;
      end_seen_q   <= 1'b0;
      prev_store_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      total_q      <= total_d;
      start_q      <= start_d;
      loop_q       <= loop_d;
      events_q     <= events_d;
      end_seen_q   <= end_seen_d;
      prev_store_q <= prev_store_d;
    end
  end

  generate
    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
      logic [ADDR_W-1:0] w_lo;
      logic [ADDR_W-1:0] w_hi;
      logic              w_hit;
      logic [CNT_W-1:0]  count_q, count_d;
      logic [ADDR_W-1:0] last_q, last_d;

      assign w_lo  = cfg_region_lo[r*ADDR_W +: ADDR_W];
      assign w_hi  = cfg_region_hi[r*ADDR_W +: ADDR_W];
      // An inverted window (lo > hi) can never satisfy both bounds.
      assign w_hit = w_count_en && store_valid && (store_addr >= w_lo) && (store_addr <= w_hi);

      assign count_d = w_hit ? cnt_inc(count_q) : count_q;
      assign last_d  = w_hit ? store_addr : last_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          count_q <= '0;
          last_q  <= '0;
        end else begin
          count_q <= count_d;
          last_q  <= last_d;
        end
      end

      assign region_count[r*CNT_W +: CNT_W]  = count_q;
      assign region_last[r*ADDR_W +: ADDR_W] = last_q;
    end
  endgenerate

  assign state_o      = state_q;
  assign total_cycles = total_q;
  assign loop_cycles  = loop_q;
  assign store_events = events_q;
  assign end_seen     = end_seen_q;
  assign done         = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_region_perf_monitor.sv
`default_nettype none
// Bench for mem_region_perf_monitor: table-driven store vectors plus hand-written
// FSM sequences; expectations are queued, then popped and compared against the DUT.
module tb_mem_region_perf_monitor;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int CW = 32;
  localparam int DR = 16;
  localparam logic [31:0] START_PC = 32'h1040;
  localparam logic [31:0] END_ADDR = 32'h3FC;

  localparam int SEL_STATE    = 0;
  localparam int SEL_TOTAL    = 1;
  localparam int SEL_LOOP     = 2;
  localparam int SEL_EVENTS   = 3;
  localparam int SEL_RC       = 4;
  localparam int SEL_RL       = 5;
  localparam int SEL_END      = 6;
  localparam int SEL_DONE     = 7;
  localparam int SEL_S_STATE  = 8;
  localparam int SEL_S_TOTAL  = 9;
  localparam int SEL_S_LOOP   = 10;
  localparam int SEL_S_EVENTS = 11;
  localparam int SEL_S_RC     = 12;
  localparam int SEL_S_RL     = 13;
  localparam int SEL_S_END    = 14;
  localparam int SEL_S_DONE   = 15;

  logic              clk;
  logic              rst;
  logic [AW-1:0]     cfg_start_pc;
  logic [AW-1:0]     cfg_end_addr;
  logic [NR*AW-1:0]  cfg_lo;
  logic [NR*AW-1:0]  cfg_hi;
  logic [AW-1:0]     pc;
  logic              sv;
  logic [AW-1:0]     sa;
  logic              ext_done;
  logic [1:0]        state_o;
  logic [CW-1:0]     total_cycles;
  logic [CW-1:0]     loop_cycles;
  logic [CW-1:0]     store_events;
  logic [NR*CW-1:0]  region_count;
  logic [NR*AW-1:0]  region_last;
  logic              end_seen;
  logic              done;

  logic              s_sv;
  logic [AW-1:0]     s_sa;
  logic [AW-1:0]     s_lo;
  logic [AW-1:0]     s_hi;
  logic [1:0]        s_state;
  logic [3:0]        s_total;
  logic [3:0]        s_loop;
  logic [3:0]        s_events;
  logic [3:0]        s_rc;
  logic [AW-1:0]     s_rl;
  logic              s_end_seen;
  logic              s_done;

  mem_region_perf_monitor #(
    .NUM_REGIONS(NR), .ADDR_W(AW), .CNT_W(CW), .DRAIN_CYCLES(DR)
  ) u_dut (
    .clk(clk), .reset(rst),
    .cfg_start_pc(cfg_start_pc), .cfg_end_addr(cfg_end_addr),
    .cfg_region_lo(cfg_lo), .cfg_region_hi(cfg_hi),
    .pc(pc), .store_valid(sv), .store_addr(sa), .ext_done(ext_done),
    .state_o(state_o), .total_cycles(total_cycles), .loop_cycles(loop_cycles),
    .store_events(store_events), .region_count(region_count),
    .region_last(region_last), .end_seen(end_seen), .done(done)
  );

  mem_region_perf_monitor #(
    .NUM_REGIONS(1), .ADDR_W(AW), .CNT_W(4), .DRAIN_CYCLES(4)
  ) u_small (
    .clk(clk), .reset(rst),
    .cfg_start_pc(cfg_start_pc), .cfg_end_addr(cfg_end_addr),
    .cfg_region_lo(s_lo), .cfg_region_hi(s_hi),
    .pc(pc), .store_valid(s_sv), .store_addr(s_sa), .ext_done(1'b0),
    .state_o(s_state), .total_cycles(s_total), .loop_cycles(s_loop),
    .store_events(s_events), .region_count(s_rc),
    .region_last(s_rl), .end_seen(s_end_seen), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          sel;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    logic [31:0] lo0, hi0, lo1, hi1, base, stride;
    int          n, hold, gap;
    logic [31:0] exp_rc0, exp_rc1, exp_ev, exp_last0, exp_last1;
  } vec_t;

  exp_t        sb[$];
  string       sb_name[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int unsigned cyc     = 0;
  vec_t        vecs[6];

  // Reference cycle count: cleared while reset is sampled high, +1 otherwise.
  task automatic tick();
    @(posedge clk);
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
    #1;
  endtask

  task automatic expect_val(input string name, input int sel, input int idx, input logic [31:0] e);
    exp_t x;
    x.sel = sel;
    x.idx = idx;
    x.exp = e;
    sb.push_back(x);
    sb_name.push_back(name);
  endtask

  function automatic logic [31:0] sample(input int sel, input int idx);
    logic [31:0] v;
    v = '0;
    case (sel)
      SEL_STATE:    v = {30'd0, state_o};
      SEL_TOTAL:    v = total_cycles;
      SEL_LOOP:     v = loop_cycles;
      SEL_EVENTS:   v = store_events;
      SEL_RC:       v = region_count[idx*CW +: CW];
      SEL_RL:       v = region_last[idx*AW +: AW];
      SEL_END:      v = {31'd0, end_seen};
      SEL_DONE:     v = {31'd0, done};
      SEL_S_STATE:  v = {30'd0, s_state};
      SEL_S_TOTAL:  v = {28'd0, s_total};
      SEL_S_LOOP:   v = {28'd0, s_loop};
      SEL_S_EVENTS: v = {28'd0, s_events};
      SEL_S_RC:     v = {28'd0, s_rc};
      SEL_S_RL:     v = s_rl;
      SEL_S_END:    v = {31'd0, s_end_seen};
      SEL_S_DONE:   v = {31'd0, s_done};
      default:      v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  task automatic check_sb();
    exp_t        x;
    string       nm;
    logic [31:0] act;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      nm  = sb_name.pop_front();
      act = sample(x.sel, x.idx);
      n_total = n_total + 1;
      if (act === x.exp) n_pass = n_pass + 1;
      else $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", nm, act, x.exp, $time);
    end
  endtask

  task automatic expect_zero(input string tag);
    expect_val({tag, " state"},  SEL_STATE,  0, 32'd0);
    expect_val({tag, " total"},  SEL_TOTAL,  0, 32'd0);
    expect_val({tag, " loop"},   SEL_LOOP,   0, 32'd0);
    expect_val({tag, " events"}, SEL_EVENTS, 0, 32'd0);
    expect_val({tag, " rc0"},    SEL_RC,     0, 32'd0);
    expect_val({tag, " rc1"},    SEL_RC,     1, 32'd0);
    expect_val({tag, " rl0"},    SEL_RL,     0, 32'd0);
    expect_val({tag, " rl1"},    SEL_RL,     1, 32'd0);
    expect_val({tag, " end"},    SEL_END,    0, 32'd0);
    expect_val({tag, " done"},   SEL_DONE,   0, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; pc = '0; sv = 1'b0; sa = '0; ext_done = 1'b0;
    s_sv = 1'b0; s_sa = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic single_store(input logic [31:0] addr);
    sa = addr; sv = 1'b1; tick();
    sv = 1'b0; tick();
  endtask

  initial begin
    vec_t v;
    int   k;
    vecs[0] = '{32'h300, 32'h3FC, 32'h100, 32'h1FC, 32'h300, 32'd4, 64, 1, 1, 32'd64, 32'd0, 32'd64, 32'h3FC, 32'h0};
    vecs[1] = '{32'h300, 32'h3FC, 32'h100, 32'h1FC, 32'h300, 32'd0, 1, 3, 1, 32'd3, 32'd0, 32'd1, 32'h300, 32'h0};
    vecs[2] = '{32'h300, 32'h3FC, 32'h380, 32'h400, 32'h390, 32'd0, 1, 3, 1, 32'd3, 32'd3, 32'd1, 32'h390, 32'h390};
    vecs[3] = '{32'h0, 32'hFFFF_FFFF, 32'h400, 32'h100, 32'h200, 32'd4, 5, 1, 1, 32'd5, 32'd0, 32'd5, 32'h210, 32'h0};
    vecs[4] = '{32'h300, 32'h300, 32'h304, 32'h3FC, 32'h2FC, 32'd4, 3, 1, 1, 32'd1, 32'd1, 32'd3, 32'h300, 32'h304};
    vecs[5] = '{32'h300, 32'h3FC, 32'h100, 32'h1FC, 32'h300, 32'd4, 4, 1, 0, 32'd4, 32'd0, 32'd1, 32'h30C, 32'h0};

    cfg_start_pc = START_PC;
    cfg_end_addr = END_ADDR;
    cfg_lo = {32'h100, 32'h300};
    cfg_hi = {32'h1FC, 32'h3FC};
    s_lo = 32'h0;
    s_hi = 32'hFFFF_FFFF;

    // Reset held 3 cycles, then 10 idle cycles.
    rst = 1'b1; pc = '0; sv = 1'b0; sa = '0; ext_done = 1'b0; s_sv = 1'b0; s_sa = '0;
    repeat (3) tick();
    expect_zero("reset");
    check_sb();
    rst = 1'b0;
    repeat (10) tick();
    expect_val("idle total", SEL_TOTAL, 0, 32'd10);
    expect_val("idle state", SEL_STATE, 0, 32'd0);
    check_sb();

    // Store vectors (all in IDLE; end-address stores there do not end anything).
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      do_reset();
      cfg_lo = {v.lo1, v.lo0};
      cfg_hi = {v.hi1, v.hi0};
      expect_val($sformatf("vec%0d rc0", i),    SEL_RC,     0, v.exp_rc0);
      expect_val($sformatf("vec%0d rc1", i),    SEL_RC,     1, v.exp_rc1);
      expect_val($sformatf("vec%0d events", i), SEL_EVENTS, 0, v.exp_ev);
      expect_val($sformatf("vec%0d rl0", i),    SEL_RL,     0, v.exp_last0);
      expect_val($sformatf("vec%0d rl1", i),    SEL_RL,     1, v.exp_last1);
      expect_val($sformatf("vec%0d state", i),  SEL_STATE,  0, 32'd0);
      expect_val($sformatf("vec%0d end", i),    SEL_END,    0, 32'd0);
      for (int j = 0; j < v.n; j++) begin
        sa = v.base + v.stride * 32'(j);
        sv = 1'b1;
        repeat (v.hold) tick();
        if (v.gap != 0) begin
          sv = 1'b0;
          tick();
        end
      end
      sv = 1'b0;
      tick();
      expect_val($sformatf("vec%0d total", i), SEL_TOTAL, 0, cyc);
      check_sb();
    end

    // Loop timing: start fetch at cycle 5, end store at cycle 104.
    cfg_lo = {32'h100, 32'h300};
    cfg_hi = {32'h1FC, 32'h3FC};
    do_reset();
    repeat (5) tick();
    pc = START_PC;
    tick();
    pc = '0;
    expect_val("run state", SEL_STATE, 0, 32'd1);
    check_sb();
    while (cyc < 104) tick();
    sa = END_ADDR; sv = 1'b1;
    expect_val("loop cycles", SEL_LOOP,   0, 32'd100);
    expect_val("loop end",    SEL_END,    0, 32'd1);
    expect_val("loop state",  SEL_STATE,  0, 32'd2);
    expect_val("loop done0",  SEL_DONE,   0, 32'd0);
    expect_val("loop events", SEL_EVENTS, 0, 32'd1);
    expect_val("loop rc0",    SEL_RC,     0, 32'd1);
    tick();
    sv = 1'b0;
    check_sb();
    repeat (DR - 1) tick();
    expect_val("drain last state", SEL_STATE, 0, 32'd2);
    expect_val("drain last done",  SEL_DONE,  0, 32'd0);
    check_sb();
    tick();
    expect_val("done flag",  SEL_DONE,  0, 32'd1);
    expect_val("done state", SEL_STATE, 0, 32'd3);
    expect_val("done total", SEL_TOTAL, 0, cyc);
    check_sb();
    repeat (3) single_store(32'h300);
    expect_val("done events frozen", SEL_EVENTS, 0, 32'd1);
    expect_val("done rc0 frozen",    SEL_RC,     0, 32'd1);
    expect_val("done rl0 frozen",    SEL_RL,     0, 32'h3FC);
    expect_val("done total runs",    SEL_TOTAL,  0, cyc);
    expect_val("done sticky",        SEL_DONE,   0, 32'd1);
    check_sb();

    // ext_done in IDLE: drain without a loop measurement.
    do_reset();
    repeat (3) tick();
    ext_done = 1'b1;
    tick();
    ext_done = 1'b0;
    expect_val("ext state", SEL_STATE, 0, 32'd2);
    expect_val("ext end",   SEL_END,   0, 32'd0);
    expect_val("ext loop",  SEL_LOOP,  0, 32'd0);
    check_sb();
    single_store(32'h300);
    expect_val("drain events", SEL_EVENTS, 0, 32'd1);
    expect_val("drain rc0",    SEL_RC,     0, 32'd1);
    expect_val("drain rl0",    SEL_RL,     0, 32'h300);
    check_sb();
    k = 0;
    while (!done && k < DR + 4) begin
      tick();
      k++;
    end
    expect_val("ext done reached", SEL_DONE, 0, 32'd1);
    check_sb();
    repeat (3) single_store(32'h304);
    expect_val("ext done events", SEL_EVENTS, 0, 32'd1);
    expect_val("ext done rc0",    SEL_RC,     0, 32'd1);
    expect_val("ext done total",  SEL_TOTAL,  0, cyc);
    check_sb();

    // RUN -> DRAIN via ext_done, then the first end store in DRAIN wins.
    do_reset();
    repeat (2) tick();
    pc = START_PC;
    tick();
    pc = '0;
    while (cyc < 10) tick();
    ext_done = 1'b1;
    tick();
    ext_done = 1'b0;
    expect_val("runext state", SEL_STATE, 0, 32'd2);
    expect_val("runext end",   SEL_END,   0, 32'd0);
    check_sb();
    tick();
    single_store(END_ADDR);
    sa = END_ADDR; sv = 1'b1;
    tick();
    sv = 1'b0;
    expect_val("first hit loop",  SEL_LOOP,  0, 32'd11);
    expect_val("first hit end",   SEL_END,   0, 32'd1);
    expect_val("first hit state", SEL_STATE, 0, 32'd2);
    check_sb();

    // Start and end in the same IDLE cycle; held store ends the loop next cycle.
    do_reset();
    repeat (3) tick();
    pc = START_PC; sa = END_ADDR; sv = 1'b1;
    tick();
    pc = '0;
    expect_val("same-cycle state", SEL_STATE, 0, 32'd1);
    expect_val("same-cycle end",   SEL_END,   0, 32'd0);
    check_sb();
    tick();
    sv = 1'b0;
    expect_val("same-cycle loop",   SEL_LOOP,   0, 32'd2);
    expect_val("same-cycle end2",   SEL_END,    0, 32'd1);
    expect_val("same-cycle events", SEL_EVENTS, 0, 32'd1);
    check_sb();

    // Reset mid-DRAIN: zeros next cycle, no done afterwards.
    repeat (3) tick();
    rst = 1'b1;
    tick();
    expect_zero("midreset");
    check_sb();
    rst = 1'b0;
    repeat (DR + 4) tick();
    expect_val("post-reset done",  SEL_DONE,  0, 32'd0);
    expect_val("post-reset state", SEL_STATE, 0, 32'd0);
    expect_val("post-reset total", SEL_TOTAL, 0, cyc);
    check_sb();

    // Narrow counters: 20 store events on a 4-bit instance.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_sa = 32'h10 * 32'(i);
      s_sv = 1'b1;
      tick();
      s_sv = 1'b0;
      tick();
    end
    tick();
`ifdef PERF_MON_SAT_EN
    expect_val("narrow events", SEL_S_EVENTS, 0, 32'd15);
    expect_val("narrow rc",     SEL_S_RC,     0, 32'd15);
    expect_val("narrow total",  SEL_S_TOTAL,  0, (cyc > 15) ? 32'd15 : cyc);
`else
    expect_val("narrow events", SEL_S_EVENTS, 0, 32'd4);
    expect_val("narrow rc",     SEL_S_RC,     0, 32'd4);
    expect_val("narrow total",  SEL_S_TOTAL,  0, cyc & 32'hF);
`endif
    expect_val("narrow rl",    SEL_S_RL,    0, 32'h130);
    expect_val("narrow state", SEL_S_STATE, 0, 32'd0);
    expect_val("narrow loop",  SEL_S_LOOP,  0, 32'd0);
    expect_val("narrow end",   SEL_S_END,   0, 32'd0);
    expect_val("narrow done",  SEL_S_DONE,  0, 32'd0);
    check_sb();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
